// File: rtl/act_bitplane_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module  : act_seq_pkg
// Brief   : Shared mode encodings, size defaults and plane-count helper for
//           the activation bit-plane sequencer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package act_seq_pkg;

   localparam int LANES_DEF = 8;
   localparam int ABITS_DEF = 8;

   typedef logic [2:0] mode_t;

   localparam mode_t MODE_FP16 = 3'b000;
   localparam mode_t MODE_FP8  = 3'b001;
   localparam mode_t MODE_INT8 = 3'b010;
   localparam mode_t MODE_INT4 = 3'b011;
   localparam mode_t MODE_INT1 = 3'b100;

   // Number of beats a word occupies; reserved encodings behave as INT1.
   function automatic logic [3:0] plane_count(input mode_t mode);
      case (mode)
         MODE_FP16, MODE_FP8: plane_count = 4'd1;
         MODE_INT8:           plane_count = 4'd8;
         MODE_INT4:           plane_count = 4'd4;
         default:             plane_count = 4'd1;
      endcase
   endfunction

   function automatic logic is_fp_mode(input mode_t mode);
      is_fp_mode = (mode == MODE_FP16) || (mode == MODE_FP8);
   endfunction

endpackage

`default_nettype wire

// File: rtl/act_bitplane_sequencer_if.sv
//------------------------------------------------------------------------------
// Module  : act_bitplane_sequencer_if
// Brief   : Input word handshake plus output beat stream of the sequencer.
//           master = upstream feeder / downstream sink side, slave = sequencer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface act_bitplane_sequencer_if #(
   parameter int LANES = act_seq_pkg::LANES_DEF,
   parameter int ABITS = act_seq_pkg::ABITS_DEF
);
   logic [2:0]             mode;
   logic                   in_valid;
   logic                   in_ready;
   logic [LANES*ABITS-1:0] in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [LANES-1:0]       out_activations;
   logic                   out_zero;
   logic                   out_neg;
   logic [2:0]             out_mode;
   logic [2:0]             out_plane_idx;
   logic                   out_last;

   modport master (
      output mode, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_activations, out_zero, out_neg,
             out_mode, out_plane_idx, out_last
   );

   modport slave (
      input  mode, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_activations, out_zero, out_neg,
             out_mode, out_plane_idx, out_last
   );
endinterface

`default_nettype wire

// File: rtl/act_bitplane_sequencer_fp_flag_decode.sv
//------------------------------------------------------------------------------
// Module  : fp_flag_decode
// Brief   : Sign and exact-zero flags of an FP16 / FP8-E4M3 operand.
//           Subnormals are not zero; integer modes report both flags low.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module fp_flag_decode
   import act_seq_pkg::*;
(
   input  mode_t       i_mode,
   input  logic [15:0] i_data,
   output logic        o_zero,
   output logic        o_neg
);

   // Select sign bit and magnitude field by FP format
   always_comb begin
      o_zero = 1'b0;
      o_neg  = 1'b0;
      case (i_mode)
         MODE_FP16: begin
            o_neg  = i_data[15];
            o_zero = (i_data[14:0] == 15'd0);
         end
         MODE_FP8: begin
            o_neg  = i_data[7];
            o_zero = (i_data[6:0] == 7'd0);
         end
         default: begin
            o_zero = 1'b0;
            o_neg  = 1'b0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/act_bitplane_sequencer.sv
//------------------------------------------------------------------------------
// Module  : act_bitplane_sequencer
// Brief   : Captures one activation word per handshake and emits registered
//           beats: one flag beat for FP modes, MSB-first bit-planes for INT.
//           Optional macro SKIP_ZERO_PLANE_EN drops all-zero non-final INT
//           planes (one plane examined per cycle).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module act_bitplane_sequencer
   import act_seq_pkg::*;
#(
   parameter int LANES = LANES_DEF,
   parameter int ABITS = ABITS_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   act_bitplane_sequencer_if.slave   bus
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]             r_state;
   logic [LANES*ABITS-1:0] r_word;
   logic                   r_out_valid;
   logic [LANES-1:0]       r_out_act;
   logic                   r_out_zero;
   logic                   r_out_neg;
   mode_t                  r_out_mode;
   logic [2:0]             r_out_idx;
   logic                   r_out_last;

   logic                   w_in_ready;
   logic                   w_capture;
   logic                   w_accept;
   logic                   w_advance;
   logic [LANES*ABITS-1:0] w_src_word;
   mode_t                  w_src_mode;
   logic [2:0]             w_eval_idx;
   logic [LANES-1:0]       w_eval_act;
   logic                   w_src_fp;
   logic                   w_eval_last;
   logic                   w_skip;
   logic                   w_fp_zero;
   logic                   w_fp_neg;

   // A new word may enter while idle or in the same cycle the last beat leaves
   assign w_in_ready = (r_state == ST_IDLE) ||
                       (r_out_valid && bus.out_ready && r_out_last);
   assign w_capture  = bus.in_valid && w_in_ready;
   assign w_accept   = r_out_valid && bus.out_ready;
   // Move to the next plane after a non-final accept, or while scanning
   // past skipped planes (held beat invalid but word still in flight)
   assign w_advance  = (r_state == ST_BUSY) &&
                       (w_accept ? !r_out_last : !r_out_valid);

   // Plane under evaluation: top plane of a fresh word, else one below the last
   always_comb begin
      w_src_word = w_capture ? bus.in_data : r_word;
      w_src_mode = w_capture ? mode_t'(bus.mode) : r_out_mode;
      w_eval_idx = w_capture ? 3'(plane_count(bus.mode) - 4'd1)
                             : (r_out_idx - 3'd1);
   end

   // Gather bit w_eval_idx of every lane into one plane
   always_comb begin
      w_eval_act = '0;
      for (int i = 0; i < LANES; i++) begin
         w_eval_act[i] = w_src_word[i*ABITS + int'(w_eval_idx)];
      end
   end

   assign w_src_fp    = is_fp_mode(w_src_mode);
   assign w_eval_last = (w_eval_idx == 3'd0);

`ifdef SKIP_ZERO_PLANE_EN
   assign w_skip = !w_src_fp && !w_eval_last && (w_eval_act == '0);
`else
   assign w_skip = 1'b0;
`endif

   fp_flag_decode u_fp_flag_decode (
      .i_mode (w_src_mode),
      .i_data (w_src_word[15:0]),
      .o_zero (w_fp_zero),
      .o_neg  (w_fp_neg)
   );

   // Beat register: load a new plane on capture/advance, retire on final accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_word      <= '0;
         r_out_valid <= 1'b0;
         r_out_act   <= '0;
         r_out_zero  <= 1'b0;
         r_out_neg   <= 1'b0;
         r_out_mode  <= MODE_FP16;
         r_out_idx   <= 3'd0;
         r_out_last  <= 1'b0;
      end else if (w_capture || w_advance) begin
         if (w_capture) begin
            r_word     <= bus.in_data;
            r_out_mode <= bus.mode;
         end
         r_state     <= ST_BUSY;
         r_out_valid <= !w_skip;
         r_out_act   <= w_src_fp ? '0 : w_eval_act;
         r_out_zero  <= w_fp_zero;
         r_out_neg   <= w_fp_neg;
         r_out_idx   <= w_eval_idx;
         r_out_last  <= w_eval_last;
      end else if (w_accept) begin
         r_state     <= ST_IDLE;
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready        = w_in_ready;
   assign bus.out_valid       = r_out_valid;
   assign bus.out_activations = r_out_act;
   assign bus.out_zero        = r_out_zero;
   assign bus.out_neg         = r_out_neg;
   assign bus.out_mode        = r_out_mode;
   assign bus.out_plane_idx   = r_out_idx;
   assign bus.out_last        = r_out_last;

endmodule

`default_nettype wire

// File: tb/tb_act_bitplane_sequencer.sv
//------------------------------------------------------------------------------
// Module  : tb_act_bitplane_sequencer
// Brief   : Directed self-checking bench for act_bitplane_sequencer.
//           Expectations follow SKIP_ZERO_PLANE_EN when it is defined.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_act_bitplane_sequencer;
   import act_seq_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   int q_idx[$];
   int q_act[$];
   int q_mode[$];
   int q_last[$];
   int e_idx[$];
   int e_act[$];

   always #5 clk = ~clk;

   act_bitplane_sequencer_if bus ();

   act_bitplane_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_beat(input string tag, input int idx, input int act,
                           input int last, input int md);
      chk({tag, ".valid"}, 32'(bus.out_valid), 1);
      chk({tag, ".idx"},   32'(bus.out_plane_idx), idx);
      chk({tag, ".act"},   32'(bus.out_activations), act);
      chk({tag, ".last"},  32'(bus.out_last), last);
      chk({tag, ".mode"},  32'(bus.out_mode), md);
   endtask

   // Accept every beat with out_ready high until the final beat leaves
   task automatic collect(input string tag, input int max_cyc);
      bit done = 1'b0;
      q_idx.delete(); q_act.delete(); q_mode.delete(); q_last.delete();
      bus.out_ready = 1'b1;
      for (int c = 0; c < max_cyc && !done; c++) begin
         if (bus.out_valid) begin
            q_idx.push_back(int'(bus.out_plane_idx));
            q_act.push_back(int'(bus.out_activations));
            q_mode.push_back(int'(bus.out_mode));
            q_last.push_back(int'(bus.out_last));
            if (bus.out_last) done = 1'b1;
         end
         step();
      end
      chk({tag, ".done"}, 32'(done), 1);
   endtask

   task automatic chk_seq(input string tag, input int md);
      chk({tag, ".beats"}, q_idx.size(), e_idx.size());
      for (int k = 0; k < e_idx.size() && k < q_idx.size(); k++) begin
         chk($sformatf("%s.b%0d.idx", tag, k),  q_idx[k], e_idx[k]);
         chk($sformatf("%s.b%0d.act", tag, k),  q_act[k], e_act[k]);
         chk($sformatf("%s.b%0d.last", tag, k), q_last[k], (k == e_idx.size()-1) ? 1 : 0);
         chk($sformatf("%s.b%0d.mode", tag, k), q_mode[k], md);
      end
      e_idx.delete(); e_act.delete();
   endtask

   task automatic send(input logic [2:0] md, input logic [63:0] data);
      bus.mode = md; bus.in_data = data; bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0; bus.in_data = '0; bus.mode = MODE_FP16; bus.out_ready = 1'b0;
      rst_n = 1'b0;
      step(); step();
      chk("rst.valid", 32'(bus.out_valid), 0);
      chk("rst.last",  32'(bus.out_last), 0);
      chk("rst.act",   32'(bus.out_activations), 0);
      chk("rst.idx",   32'(bus.out_plane_idx), 0);
      chk("rst.flags", 32'({bus.out_zero, bus.out_neg}), 0);
      chk("rst.mode",  32'(bus.out_mode), 0);
      @(negedge clk); rst_n = 1'b1;
      step();
      chk("rst.in_ready", 32'(bus.in_ready), 1);

      // FP16 negative zero: one beat, latency 1
      bus.out_ready = 1'b1;
      send(MODE_FP16, 64'h8000);
      chk_beat("fp16_nz", 0, 0, 1, MODE_FP16);
      chk("fp16_nz.zero", 32'(bus.out_zero), 1);
      chk("fp16_nz.neg",  32'(bus.out_neg), 1);
      step();
      chk("fp16_nz.drop", 32'(bus.out_valid), 0);
      chk("fp16_nz.in_ready", 32'(bus.in_ready), 1);

      // FP16 smallest subnormal is not zero
      send(MODE_FP16, 64'h0001);
      chk("fp16_sub.zero", 32'(bus.out_zero), 0);
      chk("fp16_sub.neg",  32'(bus.out_neg), 0);
      step();

      // FP16 +0: upper lanes are ignored
      send(MODE_FP16, 64'hFFFF_FFFF_FFFF_0000);
      chk("fp16_pz.zero", 32'(bus.out_zero), 1);
      chk("fp16_pz.neg",  32'(bus.out_neg), 0);
      chk("fp16_pz.act",  32'(bus.out_activations), 0);
      step();

      // FP8 0xC0: negative, non-zero
      send(MODE_FP8, 64'h00C0);
      chk_beat("fp8", 0, 0, 1, MODE_FP8);
      chk("fp8.zero", 32'(bus.out_zero), 0);
      chk("fp8.neg",  32'(bus.out_neg), 1);
      step();

      // FP8 -0 uses only bits [7:0]
      send(MODE_FP8, 64'h7F80);
      chk("fp8_nz.zero", 32'(bus.out_zero), 1);
      chk("fp8_nz.neg",  32'(bus.out_neg), 1);
      step();

      // INT8: lane7=0x80, lane0=0x01
      send(MODE_INT8, 64'h8000_0000_0000_0001);
`ifdef SKIP_ZERO_PLANE_EN
      e_idx.push_back(7); e_act.push_back('h80);
      e_idx.push_back(0); e_act.push_back('h01);
`else
      for (int k = 0; k < 8; k++) begin
         e_idx.push_back(7 - k);
         e_act.push_back(k == 0 ? 'h80 : (k == 7 ? 'h01 : 0));
      end
`endif
      collect("int8", 20);
      chk_seq("int8", MODE_INT8);

      // INT8 all-zero word
      send(MODE_INT8, 64'h0);
`ifdef SKIP_ZERO_PLANE_EN
      e_idx.push_back(0); e_act.push_back(0);
`else
      for (int k = 0; k < 8; k++) begin
         e_idx.push_back(7 - k); e_act.push_back(0);
      end
`endif
      collect("int8z", 20);
      chk_seq("int8z", MODE_INT8);

      // INT4 backpressure, lane0=0xA, mode changed after capture
      bus.out_ready = 1'b0;
      send(MODE_INT4, 64'h000A);
      bus.mode = MODE_FP16;
      chk_beat("int4.b0", 3, 'h01, 0, MODE_INT4);
      chk("int4.in_ready", 32'(bus.in_ready), 0);
      step();
      chk_beat("int4.hold1", 3, 'h01, 0, MODE_INT4);
      step();
      chk_beat("int4.hold2", 3, 'h01, 0, MODE_INT4);
      bus.out_ready = 1'b1;
      step();
`ifdef SKIP_ZERO_PLANE_EN
      chk("int4.scan", 32'(bus.out_valid), 0);
      step();
      chk_beat("int4.b1", 1, 'h01, 0, MODE_INT4);
`else
      chk_beat("int4.b1", 2, 'h00, 0, MODE_INT4);
      bus.out_ready = 1'b0;
      step();
      chk_beat("int4.hold3", 2, 'h00, 0, MODE_INT4);
      bus.out_ready = 1'b1;
      step();
      chk_beat("int4.b2", 1, 'h01, 0, MODE_INT4);
`endif
      step();
      chk_beat("int4.last", 0, 'h00, 1, MODE_INT4);
      step();
      chk("int4.drop", 32'(bus.out_valid), 0);

      // Back-to-back INT1 words (second uses reserved mode 111)
      bus.out_ready = 1'b1;
      bus.mode = MODE_INT1; bus.in_data = 64'hFE01_0001_0100_0100; bus.in_valid = 1'b1;
      step();
      chk_beat("b2b.a", 0, 'h5A, 1, MODE_INT1);
      bus.mode = 3'b111; bus.in_data = 64'h0101_0101_0101_0101;
      #1;
      chk("b2b.in_ready", 32'(bus.in_ready), 1);
      step();
      bus.in_valid = 1'b0;
      chk_beat("b2b.b", 0, 'hFF, 1, 3'b111);
      step();
      chk("b2b.drop", 32'(bus.out_valid), 0);

      // Asynchronous reset during the third beat of an INT8 word
      send(MODE_INT8, 64'h00FF);
      step(); step();
      chk_beat("rstmid.b3", 5, 'h01, 0, MODE_INT8);
      rst_n = 1'b0;
      #1;
      chk("rstmid.valid", 32'(bus.out_valid), 0);
      chk("rstmid.idx",   32'(bus.out_plane_idx), 0);
      #2;
      rst_n = 1'b1;
      step();
      chk("rstmid.in_ready", 32'(bus.in_ready), 1);
      chk("rstmid.idle",     32'(bus.out_valid), 0);
      send(MODE_INT8, 64'h0080);
`ifdef SKIP_ZERO_PLANE_EN
      e_idx.push_back(7); e_act.push_back('h01);
      e_idx.push_back(0); e_act.push_back(0);
`else
      for (int k = 0; k < 8; k++) begin
         e_idx.push_back(7 - k); e_act.push_back(k == 0 ? 'h01 : 0);
      end
`endif
      collect("rstmid.next", 20);
      chk_seq("rstmid.next", MODE_INT8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
